// File: rtl/imem_if.sv
// imem_if: fetch request/response bundle; master = fetch stage (req_valid, req_addr, resp_ready out), slave = responder (req_ready, resp_valid, resp_data, resp_err out)
interface imem_if #(
  parameter int ARCH = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [ARCH-1:0] req_addr;
  logic            resp_valid;
  logic            resp_ready;
  logic [ARCH-1:0] resp_data;
  logic            resp_err;
  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: word RAM answering one byte-addressed fetch after LATENCY cycles; ports clk, reset (sync active-high), bus (imem_if slave), load_en/load_addr/load_data (write-only load port)
module imem_responder #(
  parameter int ARCH    = 32,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_if.slave                    bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [ARCH-1:0]          load_data
);
  localparam int AW = $clog2(DEPTH);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..15");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state;
  logic [3:0]      cnt;
  logic [ARCH-1:0] mem [DEPTH];
  logic [AW-1:0]   idx_q;
  logic            err_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [ARCH-1:0] resp_data_q;
  logic [ARCH-3:0] word;
  logic            bad;
  assign word           = bus.req_addr[ARCH-1:2];
  assign bad            = |bus.req_addr[1:0] || {2'b0, word} >= ARCH'(DEPTH);
  assign bus.req_ready  = state == IDLE && !reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  always_ff @(posedge clk)
    if (load_en) mem[load_addr] <= load_data;
  // Capture reads mem through a nonblocking update, so a same-edge load is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          idx_q <= word[AW-1:0];
          err_q <= bad;
          if (LATENCY == 1) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= bad ? '0 : mem[word[AW-1:0]];
            resp_err_q   <= bad;
          end else begin
            state <= WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_data_q  <= err_q ? '0 : mem[idx_q];
            resp_err_q   <= err_q;
          end
        end
        RESP: if (bus.resp_ready) begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of a LATENCY=2 and a LATENCY=3 responder
module tb_imem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        le2 = 1'b0, le3 = 1'b0;
  logic [11:0] la2 = '0, la3 = '0;
  logic [31:0] ld2 = '0, ld3 = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  imem_if #(.ARCH(32)) bus2 ();
  imem_if #(.ARCH(32)) bus3 ();
  imem_responder #(.ARCH(32), .DEPTH(4096), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus(bus2),
    .load_en(le2), .load_addr(la2), .load_data(ld2)
  );
  imem_responder #(.ARCH(32), .DEPTH(4096), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .load_en(le3), .load_addr(la3), .load_data(ld3)
  );
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic [11:0] a, input logic [31:0] d);
    le2 = 1'b1; la2 = a; ld2 = d;
    tick;
    le2 = 1'b0;
  endtask

  task automatic load3(input logic [11:0] a, input logic [31:0] d);
    le3 = 1'b1; la3 = a; ld3 = d;
    tick;
    le3 = 1'b0;
  endtask

  // Issue one request to the LATENCY=2 unit; lat counts edges from acceptance (inclusive) to resp_valid.
  task automatic fetch2(input logic [31:0] a, output int lat, output logic [31:0] d, output logic e);
    bus2.req_valid = 1'b1; bus2.req_addr = a;
    tick;
    bus2.req_valid = 1'b0;
    lat = 1;
    while (bus2.resp_valid !== 1'b1 && lat < 30) begin
      tick;
      lat++;
    end
    d = bus2.resp_data; e = bus2.resp_err;
    bus2.resp_ready = 1'b1;
    tick;
    bus2.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    le2 = 1'b1; la2 = 12'd5; ld2 = 32'hE3A01001;
    tick;
    le2 = 1'b0;
    tick;
    n_cmp++; if (bus2.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus2.req_ready); end
    n_cmp++; if (bus2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus2.resp_valid); end
    n_cmp++; if (bus2.resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0", bus2.resp_data); end
    n_cmp++; if (bus2.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", bus2.resp_err); end
    n_cmp++; if (bus3.req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready3: got %b want 0", bus3.req_ready); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready: got %b want 1", bus2.req_ready); end
    n_cmp++; if (bus3.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_req_ready3: got %b want 1", bus3.req_ready); end
  endtask

  task automatic test_fetch;
    int lat; logic [31:0] d; logic e;
    fetch2(32'h14, lat, d, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL fetch_latency: got %0d want 2", lat); end
    n_cmp++; if (d !== 32'hE3A01001) begin n_bad++; $display("FAIL fetch_data: got %h want e3a01001", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL fetch_err: got %b want 0", e); end
    n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready_after: got %b want 1", bus2.req_ready); end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] d; logic e;
    fetch2(32'h16, lat, d, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL misalign_latency: got %0d want 2", lat); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL misalign_data: got %h want 0", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL misalign_err: got %b want 1", e); end
    fetch2(32'h4000, lat, d, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL range_latency: got %0d want 2", lat); end
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL range_data: got %h want 0", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL range_err: got %b want 1", e); end
    load2(12'hFFF, 32'hCAFEF00D);
    fetch2(32'h3FFC, lat, d, e);
    n_cmp++; if (d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL last_word_data: got %h want cafef00d", d); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b want 0", e); end
  endtask

  task automatic test_backpressure;
    int k;
    load2(12'd7, 32'h12345678);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h1C;
    tick;
    bus2.req_valid = 1'b0;
    k = 0;
    while (bus2.resp_valid !== 1'b1 && k < 20) begin
      tick;
      k++;
    end
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus2.resp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus2.resp_valid); end
      n_cmp++; if (bus2.resp_data !== 32'h12345678) begin n_bad++; $display("FAIL hold_data[%0d]: got %h want 12345678", i, bus2.resp_data); end
      n_cmp++; if (bus2.req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready[%0d]: got %b want 0", i, bus2.req_ready); end
      tick;
    end
    bus2.req_valid = 1'b0;
    bus2.resp_ready = 1'b1;
    tick;
    bus2.resp_ready = 1'b0;
    n_cmp++; if (bus2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", bus2.resp_valid); end
    n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready: got %b want 1", bus2.req_ready); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w [3];
    int issued, got, last, extra;
    logic acc;
    exp_w[0] = 32'hA0000000; exp_w[1] = 32'hA1111111; exp_w[2] = 32'hA2222222;
    load2(12'd0, exp_w[0]);
    load2(12'd1, exp_w[1]);
    load2(12'd2, exp_w[2]);
    issued = 0; got = 0; last = 0; extra = 0;
    bus2.resp_ready = 1'b1; bus2.req_valid = 1'b1; bus2.req_addr = 32'h0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      acc = bus2.req_valid && bus2.req_ready;
      if (bus2.resp_valid === 1'b1) begin
        n_cmp++; if (bus2.resp_data !== exp_w[got]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, bus2.resp_data, exp_w[got]); end
        if (got > 0) begin
          n_cmp++; if (c - last !== 3) begin n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", got, c - last); end
        end
        last = c;
        got++;
      end
      tick;
      if (acc) begin
        issued++;
        bus2.req_addr = 32'(issued * 4);
        if (issued == 3) bus2.req_valid = 1'b0;
      end
    end
    bus2.req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus2.resp_valid === 1'b1) extra++;
      tick;
    end
    bus2.resp_ready = 1'b0;
    n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", got); end
    n_cmp++; if (issued !== 3) begin n_bad++; $display("FAIL b2b_issued: got %0d want 3", issued); end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL b2b_extra: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, seen; logic [31:0] d; logic e;
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h14;
    tick;
    bus2.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus2.req_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_ready_in_reset: got %b want 0", bus2.req_ready); end
    tick;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus2.req_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready_after: got %b want 1", bus2.req_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus2.resp_valid !== 1'b0) seen++;
      tick;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_dropped: got %0d valid cycles want 0", seen); end
    fetch2(32'h14, lat, d, e);
    n_cmp++; if (d !== 32'hE3A01001) begin n_bad++; $display("FAIL midreset_recover: got %h want e3a01001", d); end
  endtask

  task automatic test_load_race;
    load3(12'd9, 32'h11111111);
    bus3.req_valid = 1'b1; bus3.req_addr = 32'h24;
    tick;
    bus3.req_valid = 1'b0;
    tick;
    le3 = 1'b1; la3 = 12'd9; ld3 = 32'h22222222;
    tick;
    le3 = 1'b0;
    n_cmp++; if (bus3.resp_valid !== 1'b1) begin n_bad++; $display("FAIL race_same_valid: got %b want 1", bus3.resp_valid); end
    n_cmp++; if (bus3.resp_data !== 32'h11111111) begin n_bad++; $display("FAIL race_same_edge: got %h want 11111111", bus3.resp_data); end
    bus3.resp_ready = 1'b1;
    tick;
    bus3.resp_ready = 1'b0;
    bus3.req_valid = 1'b1; bus3.req_addr = 32'h24;
    tick;
    bus3.req_valid = 1'b0;
    le3 = 1'b1; la3 = 12'd9; ld3 = 32'h33333333;
    tick;
    le3 = 1'b0;
    n_cmp++; if (bus3.resp_valid !== 1'b0) begin n_bad++; $display("FAIL race_early_valid: got %b want 0", bus3.resp_valid); end
    tick;
    n_cmp++; if (bus3.resp_valid !== 1'b1) begin n_bad++; $display("FAIL race_lat3_valid: got %b want 1", bus3.resp_valid); end
    n_cmp++; if (bus3.resp_data !== 32'h33333333) begin n_bad++; $display("FAIL race_earlier_edge: got %h want 33333333", bus3.resp_data); end
    bus3.resp_ready = 1'b1;
    tick;
    bus3.resp_ready = 1'b0;
  endtask

  initial begin
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.resp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_addr = '0; bus3.resp_ready = 1'b0;
    test_reset;
    test_fetch;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_load_race;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves word fetch requests issued by the ARM32 `processor` fetch stage. It holds a synchronous word RAM and accepts one byte-addressed read request at a time over a valid/ready handshake. After a fixed, parameterised latency it returns the 32-bit instruction word, or an error flag for a bad address. A separate write-only load port lets the bench or boot logic place a program image in memory before or during execution.

## Interface
- `ARCH`, 32, data and address width in bits.
- `DEPTH`, 4096, number of ARCH-bit words in memory.
- `LATENCY`, 2, cycles from request acceptance to response valid. Legal range is 1..15; values outside it are a synthesis-time error.

- `clk` input 1: single clock; all logic updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: the fetch stage presents a request.
- `req_ready` output 1: the responder can accept a request.
- `req_addr` input ARCH: byte address of the instruction.
- `resp_valid` output 1: the response is valid.
- `resp_ready` input 1: the fetch stage consumes the response.
- `resp_data` output ARCH: instruction word; 0 when `resp_err`=1.
- `resp_err` output 1: the address was misaligned or out of range.
- `load_en` input 1: write `load_data` into memory this cycle.
- `load_addr` input $clog2(DEPTH): word index for the write.
- `load_data` input ARCH: word to write.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counts down the latency.
  - RESP: `resp_valid`=1.
- Transitions:
  - IDLE→WAIT on `req_valid`&&`req_ready` when LATENCY>1. The counter loads LATENCY-1, and the address is latched.
  - IDLE→RESP directly on acceptance when LATENCY=1.
  - WAIT decrements the counter each cycle and moves to RESP in the cycle the counter is 1.
  - RESP→IDLE on `resp_valid`&&`resp_ready`.
- `req_ready` is 1 only in IDLE and only while `reset`=0. At most one request is outstanding.
- Address decode:
  - Word index = `req_addr[ARCH-1:2]`.
  - Misaligned: `req_addr[1:0]`≠0.
  - Out of range: word index ≥ DEPTH.
  - Either condition gives `resp_err`=1 and `resp_data`=0. An erroneous request still takes the full LATENCY.
- Data capture: `resp_data` and `resp_err` are registered on the edge that enters RESP. They stay stable through RESP until the handshake completes.
- Load port:
  - Writes on every edge where `load_en`=1, in any state, including during reset.
  - It never stalls the request path.
  - If a load targets the word being captured on the same edge, the old word is returned (read-before-write).
  - A load to a pending index on an earlier WAIT cycle is visible in the response.
- Memory contents are not cleared by reset.

## Timing
- Reset, on any edge with `reset`=1:
  - state←IDLE, counter←0.
  - `resp_valid`=0, `resp_data`=0, `resp_err`=0.
  - `req_ready`=0 while `reset` is high.
- Reset takes effect mid-transaction as well: a pending request is dropped and no response is produced.
- Latency: a request accepted on edge T gives `resp_valid`=1 in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-pressure: if `resp_ready`=0, RESP holds indefinitely with data unchanged.
- Throughput: the handshake edge returns the block to IDLE, so `req_ready` rises the next cycle. Maximum throughput is one request per LATENCY+1 cycles.
- `req_ready` is combinational from state and reset and does not depend on `req_valid`.
- `resp_valid` is a registered state decode and has no combinational path from inputs.

## Test plan
- Reset, then load word 5 = 0xE3A01001 and issue a request to addr 0x14 with LATENCY=2 → `resp_valid` rises 2 cycles after acceptance with `resp_data`=0xE3A01001 and `resp_err`=0.
- Request to addr 0x16 (misaligned), then a separate request to 0x4000 with DEPTH=4096 (out of range) → each returns `resp_err`=1 and `resp_data`=0 after LATENCY cycles.
- Hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid` and the data stay stable and `req_ready`=0. Then assert `resp_ready` → IDLE, with `req_ready`=1 the next cycle.
- Drive `req_valid` continuously with incrementing addresses 0,4,8 → one response per LATENCY+1 cycles, returned in order, with no request lost or duplicated.
- Assert `reset` for one cycle while in WAIT → `resp_valid` never asserts for that request, and `req_ready`=1 in the first cycle after reset is released.
- `load_en` to the pending index on the capture edge → the old word is returned; the same load one cycle earlier in WAIT (LATENCY=3) → the new word is returned.
